// File: rtl/decoder_dcac393_pkg.sv
// Shared definitions for the DC/AC coefficient decoder.
// Holds the token type codes, the decoder FSM state set, block and
// descriptor-queue geometry, and the datapath widths used by the
// decoder top and its descriptor FIFO.
package decoder_dcac393_pkg;

    localparam int DATA_W     = 16;   // token width
    localparam int COEF_W     = 13;   // coefficient width (12-bit value plus headroom)
    localparam int BLOCK_LEN  = 64;   // coefficients per block
    localparam int DESC_DEPTH = 4;    // descriptor FIFO entries
    localparam int DC_ENTRIES = 8;    // DC predictor slots, one per component number
    localparam int DESC_W     = 4;    // {comp_number[2:0], comp_first}

    // Token type codes: DC/AC use din[15:14], RLL/EOB use din[15:12]
    localparam logic [1:0] TOK_DC  = 2'b11;
    localparam logic [1:0] TOK_AC  = 2'b10;
    localparam logic [3:0] TOK_RLL = 4'b0000;
    localparam logic [3:0] TOK_EOB = 4'b0001;

    localparam logic [5:0] LAST_POS = 6'(BLOCK_LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        DCRD,
        AC,
        ZRUN,
        FILL
    } state_t;

endpackage

// File: rtl/decoder_dcac393_desc_fifo.sv
// Four-entry per-block descriptor queue.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   en           : synchronous enable; 0 empties the queue
//   push         : write push_data (dropped when full, flagged on overflow)
//   push_data    : {comp_number[2:0], comp_first}
//   pop          : consume the head entry
//   pop_data     : head entry (meaningful only while empty=0)
//   empty, full  : occupancy flags
//   overflow     : push attempted while full (single-cycle pulse)
module decoder_desc_fifo
    import decoder_dcac393_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              push,
    input  logic [DESC_W-1:0] push_data,
    input  logic              pop,
    output logic [DESC_W-1:0] pop_data,
    output logic              empty,
    output logic              full,
    output logic              overflow
);

    localparam int PTR_W = $clog2(DESC_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   CNT_DEPTH = (PTR_W + 1)'(DESC_DEPTH);

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic [DESC_W-1:0] mem [DESC_DEPTH];
    logic              do_push;
    logic              do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_DEPTH);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign overflow = push && full;
    assign pop_data = mem[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Pointers are log2(depth) wide so they wrap naturally
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        if (!en) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid
    always_ff @(posedge clk) begin
        if (do_push && en) mem[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/decoder_dcac393.sv
// DC/AC token decoder: turns a DC/AC/RLL/EOB token stream into 64
// zigzag-ordered coefficients per block, with DC prediction per component.
// Ports:
//   clk, rst_n, en              : clock, async active-low reset, sync clear
//   desc_stb/comp_number/first  : descriptor push (one per block)
//   desc_full                   : descriptor FIFO full
//   din, din_valid, din_ready   : token stream handshake
//   coef, coef_dv               : coefficient and its strobe
//   coef_first, coef_last       : position 0 / position 63 markers
//   blk_comp_number/color/last  : block fields, valid while coef_first=1
//   err                         : sticky protocol error
module decoder_dcac393
    import decoder_dcac393_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     desc_stb,
    input  logic [2:0]               desc_comp_number,
    input  logic                     desc_comp_first,
    output logic                     desc_full,
    input  logic [DATA_W-1:0]        din,
    input  logic                     din_valid,
    output logic                     din_ready,
    output logic signed [COEF_W-1:0] coef,
    output logic                     coef_dv,
    output logic                     coef_first,
    output logic                     coef_last,
    output logic [2:0]               blk_comp_number,
    output logic                     blk_color,
    output logic                     blk_last,
    output logic                     err
);

    function automatic logic [COEF_W-1:0] sext12(input logic [11:0] v);
        return {v[11], v};
    endfunction

    state_t            state_q, state_d;
    logic [5:0]        pos_q, pos_d;
    logic [5:0]        run_q, run_d;
    logic [11:0]       diff_q, diff_d;
    logic              comp_first_q, comp_first_d;
    logic [COEF_W-1:0] coef_q, coef_d;
    logic              coef_dv_q, coef_dv_d;
    logic              coef_first_q, coef_first_d;
    logic              coef_last_q, coef_last_d;
    logic [2:0]        blk_comp_q, blk_comp_d;
    logic              blk_color_q, blk_color_d;
    logic              blk_last_q, blk_last_d;
    logic              err_q, err_d;

    logic [COEF_W-1:0] dc_mem [DC_ENTRIES];
    logic [COEF_W-1:0] dc_prev;
    logic [COEF_W-1:0] dc_sum;
    logic              dc_we;
    logic              ready_c;
    logic              fifo_pop;
    logic [DESC_W-1:0] fifo_head;
    logic              fifo_empty;
    logic              fifo_ovf;

    decoder_desc_fifo u_desc_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .push      (desc_stb),
        .push_data ({desc_comp_number, desc_comp_first}),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .empty     (fifo_empty),
        .full      (desc_full),
        .overflow  (fifo_ovf)
    );

    // First block of a component predicts from zero, later blocks from the stored DC
    assign dc_prev = comp_first_q ? '0 : dc_mem[blk_comp_q];
    assign dc_sum  = dc_prev + sext12(diff_q);
    assign dc_we   = (state_q == DCRD) && en;

    always_comb begin
        state_d      = state_q;
        pos_d        = pos_q;
        run_d        = run_q;
        diff_d       = diff_q;
        comp_first_d = comp_first_q;
        coef_d       = coef_q;
        coef_dv_d    = 1'b0;
        coef_first_d = 1'b0;
        coef_last_d  = 1'b0;
        blk_comp_d   = blk_comp_q;
        blk_color_d  = blk_color_q;
        blk_last_d   = blk_last_q;
        err_d        = err_q | fifo_ovf;
        fifo_pop     = 1'b0;
        ready_c      = 1'b0;

        case (state_q)
            IDLE: begin
                // Stall until a descriptor is available for the block
                ready_c = !fifo_empty;
                if (din_valid && ready_c) begin
                    if (din[15:14] == TOK_DC) begin
                        fifo_pop     = 1'b1;
                        blk_comp_d   = fifo_head[3:1];
                        comp_first_d = fifo_head[0];
                        blk_color_d  = din[13];
                        blk_last_d   = din[12];
                        diff_d       = din[11:0];
                        state_d      = DCRD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            DCRD: begin
                coef_d       = dc_sum;
                coef_dv_d    = 1'b1;
                coef_first_d = 1'b1;
                pos_d        = 6'd1;
                state_d      = AC;
            end

            AC: begin
                // A DC here means the block ended early: leave it on the bus
                ready_c = !(din_valid && (din[15:14] == TOK_DC));
                if (din_valid) begin
                    if (din[15:14] == TOK_DC) begin
                        err_d   = 1'b1;
                        state_d = FILL;
                    end else if (din[15:14] == TOK_AC) begin
                        coef_d    = sext12(din[11:0]);
                        coef_dv_d = 1'b1;
                        if (pos_q == LAST_POS) begin
                            coef_last_d = 1'b1;
                            pos_d       = '0;
                            state_d     = IDLE;
                        end else begin
                            pos_d = pos_q + 6'd1;
                            if (din[12]) begin
                                err_d   = 1'b1;
                                state_d = FILL;
                            end
                        end
                    end else if (din[15:12] == TOK_RLL) begin
                        if (din[5:0] == '0) begin
                            err_d = 1'b1;
                        end else begin
                            run_d   = din[5:0];
                            state_d = ZRUN;
                        end
                    end else if (din[15:12] == TOK_EOB) begin
                        state_d = FILL;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            ZRUN: begin
                coef_d    = '0;
                coef_dv_d = 1'b1;
                if (pos_q == LAST_POS) begin
                    // Remaining run past the block end is an overflow
                    coef_last_d = 1'b1;
                    pos_d       = '0;
                    state_d     = IDLE;
                    if (run_q != 6'd1) err_d = 1'b1;
                end else begin
                    pos_d = pos_q + 6'd1;
                    run_d = run_q - 6'd1;
                    if (run_q == 6'd1) state_d = AC;
                end
            end

            FILL: begin
                coef_d    = '0;
                coef_dv_d = 1'b1;
                if (pos_q == LAST_POS) begin
                    coef_last_d = 1'b1;
                    pos_d       = '0;
                    state_d     = IDLE;
                end else begin
                    pos_d = pos_q + 6'd1;
                end
            end

            default: state_d = IDLE;
        endcase

        if (!en) begin
            state_d      = IDLE;
            pos_d        = '0;
            run_d        = '0;
            diff_d       = '0;
            comp_first_d = 1'b0;
            coef_d       = '0;
            coef_dv_d    = 1'b0;
            coef_first_d = 1'b0;
            coef_last_d  = 1'b0;
            blk_comp_d   = '0;
            blk_color_d  = 1'b0;
            blk_last_d   = 1'b0;
            err_d        = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pos_q        <= '0;
            run_q        <= '0;
            diff_q       <= '0;
            comp_first_q <= 1'b0;
            coef_q       <= '0;
            coef_dv_q    <= 1'b0;
            coef_first_q <= 1'b0;
            coef_last_q  <= 1'b0;
            blk_comp_q   <= '0;
            blk_color_q  <= 1'b0;
            blk_last_q   <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pos_q        <= pos_d;
            run_q        <= run_d;
            diff_q       <= diff_d;
            comp_first_q <= comp_first_d;
            coef_q       <= coef_d;
            coef_dv_q    <= coef_dv_d;
            coef_first_q <= coef_first_d;
            coef_last_q  <= coef_last_d;
            blk_comp_q   <= blk_comp_d;
            blk_color_q  <= blk_color_d;
            blk_last_q   <= blk_last_d;
            err_q        <= err_d;
        end
    end

    // DC predictor store; contents are only trusted after a comp_first block
    always_ff @(posedge clk) begin
        if (dc_we) dc_mem[blk_comp_q] <= dc_sum;
    end

    assign din_ready       = ready_c && en;
    assign coef            = coef_q;
    assign coef_dv         = coef_dv_q;
    assign coef_first      = coef_first_q;
    assign coef_last       = coef_last_q;
    assign blk_comp_number = blk_comp_q;
    assign blk_color       = blk_color_q;
    assign blk_last        = blk_last_q;
    assign err             = err_q;

endmodule

// File: tb/tb_decoder_dcac393.sv
// Directed testbench for decoder_dcac393.
module tb_decoder_dcac393;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               en;
    logic               desc_stb;
    logic [2:0]         desc_comp_number;
    logic               desc_comp_first;
    logic               desc_full;
    logic [15:0]        din;
    logic               din_valid;
    logic               din_ready;
    logic signed [12:0] coef;
    logic               coef_dv;
    logic               coef_first;
    logic               coef_last;
    logic [2:0]         blk_comp_number;
    logic               blk_color;
    logic               blk_last;
    logic               err;

    decoder_dcac393 dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .en               (en),
        .desc_stb         (desc_stb),
        .desc_comp_number (desc_comp_number),
        .desc_comp_first  (desc_comp_first),
        .desc_full        (desc_full),
        .din              (din),
        .din_valid        (din_valid),
        .din_ready        (din_ready),
        .coef             (coef),
        .coef_dv          (coef_dv),
        .coef_first       (coef_first),
        .coef_last        (coef_last),
        .blk_comp_number  (blk_comp_number),
        .blk_color        (blk_color),
        .blk_last         (blk_last),
        .err              (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [12:0] v;
        logic        f;
        logic        l;
    } cw_t;

    cw_t  cap[$];
    cw_t  exp_q[$];
    int   cyc = 0;
    int   xfer_cyc;
    int   xfer_dc;
    int   dc_cyc;
    logic [2:0] dc_comp;
    logic dc_color;
    logic dc_last;
    int   n_pass;
    int   n_total;
    int   n_before;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every emitted coefficient, plus the block fields at DC time
    always @(negedge clk) begin
        if (coef_dv) begin
            cw_t w;
            w.v = coef;
            w.f = coef_first;
            w.l = coef_last;
            cap.push_back(w);
            if (coef_first) begin
                dc_cyc   = cyc;
                dc_comp  = blk_comp_number;
                dc_color = blk_color;
                dc_last  = blk_last;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_desc(input logic [2:0] c, input logic f);
        desc_comp_number = c;
        desc_comp_first  = f;
        desc_stb         = 1'b1;
        @(posedge clk);
        #1;
        desc_stb = 1'b0;
    endtask

    task automatic send(input logic [15:0] tok);
        int k;
        din       = tok;
        din_valid = 1'b1;
        for (k = 0; k < 300; k++) begin
            @(negedge clk);
            if (din_ready) break;
        end
        if (k == 300) chk("send_timeout", din_ready, 1'b1);
        xfer_cyc = cyc;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
    endtask

    task automatic wait_cap(input int n, input string tag);
        for (int k = 0; k < 300 && cap.size() < n; k++) @(negedge clk);
        repeat (2) @(negedge clk);
        chk({tag, "_count"}, cap.size(), n);
    endtask

    task automatic exp_add(input logic [12:0] v, input logic f, input logic l);
        cw_t w;
        w.v = v;
        w.f = f;
        w.l = l;
        exp_q.push_back(w);
    endtask

    task automatic exp_fill(input int from);
        for (int p = from; p < 64; p++) exp_add(13'd0, 1'b0, p == 63);
    endtask

    task automatic cmp_block(input string tag);
        int nv, nf, nl, n;
        nv = 0; nf = 0; nl = 0;
        n = (cap.size() < exp_q.size()) ? cap.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (cap[i].v !== exp_q[i].v) nv++;
            if (cap[i].f !== exp_q[i].f) nf++;
            if (cap[i].l !== exp_q[i].l) nl++;
        end
        chk({tag, "_bad_vals"},  nv, 0);
        chk({tag, "_bad_first"}, nf, 0);
        chk({tag, "_bad_last"},  nl, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        n_pass = 0;
        n_total = 0;
        rst_n = 1'b0;
        en = 1'b1;
        desc_stb = 1'b0;
        desc_comp_number = '0;
        desc_comp_first = 1'b0;
        din = '0;
        din_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_coef", coef, 0);
        chk("rst_dv", coef_dv, 0);
        chk("rst_first", coef_first, 0);
        chk("rst_last", coef_last, 0);
        chk("rst_ready", din_ready, 0);
        chk("rst_full", desc_full, 0);
        chk("rst_err", err, 0);
        chk("rst_blk", {blk_comp_number, blk_color, blk_last}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // DC basic: 100 then 63 zeros
        cap.delete();
        push_desc(3'd0, 1'b1);
        send(16'hC064);
        xfer_dc = xfer_cyc;
        send(16'h1000);
        wait_cap(64, "s1");
        exp_q.delete();
        exp_add(13'd100, 1'b1, 1'b0);
        exp_fill(1);
        cmp_block("s1");
        chk("s1_dc_latency", dc_cyc - xfer_dc, 2);
        chk("s1_comp", dc_comp, 0);
        chk("s1_err", err, 0);

        // DC chain: 100 + (-10) = 90
        cap.delete();
        push_desc(3'd0, 1'b0);
        send(16'hCFF6);
        send(16'h1000);
        wait_cap(64, "s2a");
        exp_q.delete();
        exp_add(13'd90, 1'b1, 1'b0);
        exp_fill(1);
        cmp_block("s2a");

        // Component 1 first block, color=1, last=1
        cap.delete();
        push_desc(3'd1, 1'b1);
        send(16'hF005);
        send(16'h1000);
        wait_cap(64, "s2b");
        chk("s2b_dc", cap[0].v, 13'd5);
        chk("s2b_comp", dc_comp, 1);
        chk("s2b_color", dc_color, 1);
        chk("s2b_blast", dc_last, 1);

        // Component 0 predictor untouched by component 1
        cap.delete();
        push_desc(3'd0, 1'b0);
        send(16'hC000);
        send(16'h1000);
        wait_cap(64, "s2c");
        chk("s2c_dc", cap[0].v, 13'd90);

        // Runs: 0, 3, five zeros, -1, zeros to end
        cap.delete();
        push_desc(3'd2, 1'b1);
        send(16'hC000);
        send(16'h8003);
        send(16'h0005);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("s3_run_ready", din_ready, 0);
        end
        send(16'h8FFF);
        send(16'h1000);
        wait_cap(64, "s3");
        exp_q.delete();
        exp_add(13'd0, 1'b1, 1'b0);
        exp_add(13'd3, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) exp_add(13'd0, 1'b0, 1'b0);
        exp_add(13'h1FFF, 1'b0, 1'b0);
        exp_fill(8);
        cmp_block("s3");
        chk("s3_err", err, 0);

        // Full block of AC tokens ending with last=1 at position 63
        cap.delete();
        push_desc(3'd3, 1'b1);
        send(16'hC7FF);
        for (int i = 1; i <= 62; i++) send(16'h8000 | 16'(i));
        send(16'h9ABC);
        wait_cap(64, "s4");
        exp_q.delete();
        exp_add(13'h07FF, 1'b1, 1'b0);
        for (int i = 1; i <= 62; i++) exp_add(13'(i), 1'b0, 1'b0);
        exp_add(13'h1ABC, 1'b0, 1'b1);
        cmp_block("s4");
        chk("s4_err", err, 0);
        chk("s4_idle_ready", din_ready, 0);

        // Reset in the middle of a zero run
        cap.delete();
        push_desc(3'd6, 1'b1);
        send(16'hC003);
        send(16'h0014);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("s6_dv", coef_dv, 0);
        chk("s6_coef", coef, 0);
        chk("s6_flags", {coef_first, coef_last}, 0);
        chk("s6_ready", din_ready, 0);
        chk("s6_blk", {blk_comp_number, blk_color, blk_last}, 0);
        n_before = cap.size();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("s6_no_dv", cap.size(), n_before);
        cap.delete();
        push_desc(3'd6, 1'b1);
        send(16'hC007);
        send(16'h1000);
        wait_cap(64, "s6b");
        exp_q.delete();
        exp_add(13'd7, 1'b1, 1'b0);
        exp_fill(1);
        cmp_block("s6b");
        chk("s6b_err", err, 0);

        // Descriptor FIFO full and overflow, then clear with en=0
        for (int i = 0; i < 4; i++) push_desc(3'(i), 1'b0);
        chk("fifo_full", desc_full, 1);
        chk("fifo_err_before", err, 0);
        push_desc(3'd4, 1'b0);
        chk("fifo_ovf_err", err, 1);
        en = 1'b0;
        #1;
        chk("en_ready", din_ready, 0);
        @(posedge clk);
        #1;
        chk("en_err", err, 0);
        chk("en_full", desc_full, 0);
        en = 1'b1;

        // AC in IDLE dropped; DC arriving mid-block at position 10
        cap.delete();
        push_desc(3'd4, 1'b1);
        send(16'h8001);
        @(posedge clk);
        #1;
        chk("s5_idle_err", err, 1);
        chk("s5_idle_drop", cap.size(), 0);
        send(16'hC010);
        for (int i = 0; i < 9; i++) send(16'h8001);
        push_desc(3'd5, 1'b1);
        send(16'hC020);
        wait_cap(65, "s5");
        exp_q.delete();
        exp_add(13'd16, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) exp_add(13'd1, 1'b0, 1'b0);
        exp_fill(10);
        exp_add(13'd32, 1'b1, 1'b0);
        cmp_block("s5");
        chk("s5_comp", dc_comp, 5);
        chk("s5_err_sticky", err, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
